exec_hazard_ctrl: RTL and testbench

- Hazard and sequencing controller for the execute stage of the 5-stage RV32 pipeline.
- Generates the execute-stage forwarding selects (ForwardAE/ForwardBE) and the per-stage stall/flush controls.
- Schedules a multi-cycle multiply/divide operation in E: counts its latency and freezes F/D/E until the result is ready.
- Sits beside the pipeline registers; consumes register indices and control bits from D/E/M/W.

---
 rtl/exec_hazard_ctrl_pkg.sv | 19 +
 rtl/exec_hazard_ctrl_muldiv_seq.sv | 64 ++++++
 rtl/exec_hazard_ctrl.sv | 121 ++++++++++++
 tb/tb_exec_hazard_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_hazard_ctrl_pkg.sv
// Shared types for the execute-stage hazard controller: forwarding selects,
// mul/div sequencer states and the ResultSrc encoding that marks a load.
package exec_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } md_state_t;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/exec_hazard_ctrl_muldiv_seq.sv
// Multi-cycle mul/div sequencer: holds the pipeline for MD_LATENCY-1 cycles,
// then pulses done for one cycle while the result is consumed in E.
module muldiv_seq
    import exec_pkg::*;
#(
    parameter int MD_LATENCY = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      muldiv_e,
    input  logic      pcsrc_e,
    output logic      busy,
    output logic      done,
    output md_state_t state
);

    localparam int CW = $clog2(MD_LATENCY);

    md_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // done is a single-cycle pulse with no back-pressure: the consumer in E
    // must take the result in the cycle it is asserted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (muldiv_e && !pcsrc_e) begin
                    state_d = BUSY;
                    cnt_d   = CW'(MD_LATENCY - 2);
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/exec_hazard_ctrl.sv
// Execute-stage hazard controller: forwarding selects, load-use stall, branch
// flush and mul/div freeze. Optional perf counters under HAZ_PERF_CNT_EN.
module exec_hazard_ctrl
    import exec_pkg::*;
#(
    parameter int MD_LATENCY = 4,
    parameter int XLEN       = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    input  logic [4:0]      Rs1E,
    input  logic [4:0]      Rs2E,
    input  logic [4:0]      RdE,
    input  logic [4:0]      RdM,
    input  logic [4:0]      RdW,
    input  logic            RegWriteM,
    input  logic            RegWriteW,
    input  logic [1:0]      ResultSrcE,
    input  logic            PCSrcE,
    input  logic            MulDivE,
    output logic [1:0]      ForwardAE,
    output logic [1:0]      ForwardBE,
    output logic            StallF,
    output logic            StallD,
    output logic            StallE,
    output logic            FlushD,
    output logic            FlushE,
    output logic            MulDivBusy,
`ifdef HAZ_PERF_CNT_EN
    output logic [XLEN-1:0] StallCycles,
    output logic [XLEN-1:0] FlushCount,
`endif
    output logic            MulDivDone
);

    if (MD_LATENCY < 2 || MD_LATENCY > 32 || XLEN < 1) begin : g_bad_param
        $error("exec_hazard_ctrl: MD_LATENCY must be 2..32 and XLEN positive");
    end

    function automatic fwd_sel_t fwd_pick(
        input logic       reg_write_m,
        input logic [4:0] rd_m,
        input logic       reg_write_w,
        input logic [4:0] rd_w,
        input logic [4:0] rs
    );
        if (reg_write_m && rd_m != 5'd0 && rd_m == rs) begin
            return FWD_MEM;
        end else if (reg_write_w && rd_w != 5'd0 && rd_w == rs) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    assign ForwardAE = fwd_pick(RegWriteM, RdM, RegWriteW, RdW, Rs1E);
    assign ForwardBE = fwd_pick(RegWriteM, RdM, RegWriteW, RdW, Rs2E);

    logic      load_use;
    logic      freeze;
    md_state_t md_state;

    assign load_use = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

    muldiv_seq #(
        .MD_LATENCY (MD_LATENCY)
    ) u_muldiv_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .muldiv_e (MulDivE),
        .pcsrc_e  (PCSrcE),
        .busy     (MulDivBusy),
        .done     (MulDivDone),
        .state    (md_state)
    );

    assign freeze = (md_state == BUSY);

    // Priority: mul/div freeze, then branch flush, then load-use stall.
    // Gating by rst_n keeps every control low while reset is held.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        if (rst_n) begin
            if (freeze) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (load_use) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCycles <= '0;
            FlushCount  <= '0;
        end else begin
            if (StallF && (StallCycles != '1)) begin
                StallCycles <= StallCycles + XLEN'(1);
            end
            if (FlushE && (FlushCount != '1)) begin
                FlushCount <= FlushCount + XLEN'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_exec_hazard_ctrl.sv
// Bench for exec_hazard_ctrl: directed hazard scenarios plus random traffic,
// checked by a queue-based scoreboard against a cycle-window reference model.
module tb_exec_hazard_ctrl;

    localparam int L    = 4;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [4:0]      Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic            RegWriteM, RegWriteW;
    logic [1:0]      ResultSrcE;
    logic            PCSrcE, MulDivE;
    logic [1:0]      ForwardAE, ForwardBE;
    logic            StallF, StallD, StallE, FlushD, FlushE;
    logic            MulDivBusy, MulDivDone;
`ifdef HAZ_PERF_CNT_EN
    logic [XLEN-1:0] StallCycles, FlushCount;
`endif

    exec_hazard_ctrl #(
        .MD_LATENCY (L),
        .XLEN       (XLEN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .RdM        (RdM),
        .RdW        (RdW),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .ResultSrcE (ResultSrcE),
        .PCSrcE     (PCSrcE),
        .MulDivE    (MulDivE),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .MulDivBusy (MulDivBusy),
`ifdef HAZ_PERF_CNT_EN
        .StallCycles(StallCycles),
        .FlushCount (FlushCount),
`endif
        .MulDivDone (MulDivDone)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       rwm, rww;
        logic [1:0] rsrc;
        logic       pcsrc, muldiv;
    } stim_t;

    int          errors = 0;
    int          checks = 0;
    logic [10:0] exp_q[$];
    int          cyc = 0;
    int          md_start = -1000;
    stim_t       last_s;
    logic [XLEN-1:0] exp_stall = '0;
    logic [XLEN-1:0] exp_flush = '0;

    function automatic logic [1:0] fwd_ref(input stim_t s, input logic [4:0] rs);
        if (s.rwm && s.rdm != 5'd0 && s.rdm == rs) return 2'b10;
        if (s.rww && s.rdw != 5'd0 && s.rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rs1d   = 5'($urandom_range(0, 3));
        s.rs2d   = 5'($urandom_range(0, 3));
        s.rs1e   = 5'($urandom_range(0, 3));
        s.rs2e   = 5'($urandom_range(0, 3));
        s.rde    = 5'($urandom_range(0, 3));
        s.rdm    = 5'($urandom_range(0, 3));
        s.rdw    = 5'($urandom_range(0, 3));
        s.rwm    = 1'($urandom_range(0, 1));
        s.rww    = 1'($urandom_range(0, 1));
        s.rsrc   = 2'($urandom_range(0, 3));
        s.pcsrc  = ($urandom_range(0, 5) == 0);
        s.muldiv = ($urandom_range(0, 4) == 0);
        return s;
    endfunction

    task automatic apply(input stim_t s);
        Rs1D = s.rs1d; Rs2D = s.rs2d; Rs1E = s.rs1e; Rs2E = s.rs2e;
        RdE = s.rde; RdM = s.rdm; RdW = s.rdw;
        RegWriteM = s.rwm; RegWriteW = s.rww; ResultSrcE = s.rsrc;
        PCSrcE = s.pcsrc; MulDivE = s.muldiv;
        last_s = s;
    endtask

    // One pipeline cycle: drive inputs, predict outputs, enqueue the prediction.
    task automatic drive(input stim_t s_in);
        stim_t s;
        logic  frozen, done_c, lu, sf, se, fd, fe;
        s = s_in;
        @(posedge clk);
        #1;
`ifdef HAZ_PERF_CNT_EN
        checks++;
        if (StallCycles !== exp_stall) begin
            errors++;
            $display("FAIL stall_cycles actual=%0d required=%0d", StallCycles, exp_stall);
        end
        checks++;
        if (FlushCount !== exp_flush) begin
            errors++;
            $display("FAIL flush_count actual=%0d required=%0d", FlushCount, exp_flush);
        end
`endif
        // A mul/div accepted at cycle t freezes cycles t+1..t+L-1; t+L is done.
        frozen = (cyc > md_start) && (cyc <= md_start + L - 1);
        done_c = (cyc == md_start + L);
        if (frozen) begin
            s.pcsrc  = 1'b0;
            s.muldiv = 1'b1;
        end
        apply(s);
        lu = (s.rsrc == 2'b01) && (s.rde != 5'd0) && (s.rde == s.rs1d || s.rde == s.rs2d);
        sf = frozen || (lu && !s.pcsrc);
        se = frozen;
        fd = !frozen && s.pcsrc;
        fe = !frozen && (s.pcsrc || lu);
        exp_q.push_back({fwd_ref(s, s.rs1e), fwd_ref(s, s.rs2e), sf, sf, se, fd, fe,
                         frozen, done_c});
        if (!frozen && !done_c && s.muldiv && !s.pcsrc) md_start = cyc;
        if (sf) exp_stall = exp_stall + 1;
        if (fe) exp_flush = exp_flush + 1;
        cyc++;
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({StallF, StallD, StallE, FlushD, FlushE, MulDivBusy, MulDivDone} !== 7'b0) begin
            errors++;
            $display("FAIL %s controls actual=%b required=0000000", name,
                     {StallF, StallD, StallE, FlushD, FlushE, MulDivBusy, MulDivDone});
        end
        checks++;
        if (ForwardAE !== fwd_ref(last_s, last_s.rs1e)) begin
            errors++;
            $display("FAIL %s fwd_a actual=%b required=%b", name, ForwardAE,
                     fwd_ref(last_s, last_s.rs1e));
        end
`ifdef HAZ_PERF_CNT_EN
        checks++;
        if (StallCycles !== '0 || FlushCount !== '0) begin
            errors++;
            $display("FAIL %s perf actual=%0d/%0d required=0/0", name, StallCycles, FlushCount);
        end
`endif
    endtask

    always @(negedge clk) begin
        logic [10:0] exp, act;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            act = {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE,
                   MulDivBusy, MulDivDone};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL outputs t=%0t actual=%b required=%b (fa fb sF sD sE fD fE busy done)",
                         $time, act, exp);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t z, s;
        z = '0;
        rst_n = 1'b0;
        apply(z);
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Forwarding priority: M over W, then W, then x0 never forwarded.
        s = z; s.rwm = 1; s.rdm = 5; s.rww = 1; s.rdw = 5; s.rs1e = 5; s.rs2e = 5;
        drive(s);
        s.rwm = 0;
        drive(s);
        s.rs1e = 0; s.rs2e = 0; s.rdm = 0; s.rdw = 0; s.rwm = 1;
        drive(s);

        // Load-use for one cycle, then x0 destination gives no stall.
        s = z; s.rsrc = 2'b01; s.rde = 7; s.rs2d = 7;
        drive(s);
        drive(z);
        s.rde = 0;
        drive(s);

        // Branch together with load-use: flush wins.
        s = z; s.rsrc = 2'b01; s.rde = 7; s.rs1d = 7; s.pcsrc = 1;
        drive(s);
        drive(z);

        // Two back-to-back mul/div ops, MulDivE held through both.
        s = z; s.muldiv = 1;
        repeat (10) drive(s);
        drive(z);

        // Reset in the second frozen cycle.
        drive(s);
        drive(s);
        drive(s);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_op");
        apply(z);
        md_start  = -1000;
        exp_stall = '0;
        exp_flush = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // After release: idle, then a 3-cycle freeze and one load-use stall.
        drive(z);
        repeat (5) drive(s);
        s = z; s.rsrc = 2'b01; s.rde = 3; s.rs1d = 3;
        drive(s);
        drive(z);
        drive(z);

        repeat (400) drive(rand_stim());
        repeat (3) drive(z);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending actual=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
